// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
// vga_sync_gen
//   Turns the upstream horizontal pixel count (0..H_TOTAL-1) into registered
//   VGA timing for 800x600@60 Hz. It keeps its own vertical line counter.
//   Every output lands one clk after the count value it decodes.
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   Defined   : rgb shows 8 vertical colour bars inside the active area.
//   Undefined : rgb is tied to 12'h000 and no pattern logic is built.
//
// Ports
//   clk         in   pixel clock (40 MHz)
//   rst         in   synchronous, active-high reset
//   count[10:0] in   horizontal pixel count from the upstream counter
//   hsync       out  horizontal sync, polarity set by SYNC_POS
//   vsync       out  vertical sync, polarity set by SYNC_POS
//   de          out  display enable, high inside the active region
//   x[10:0]     out  pixel column; holds its last value while de=0
//   y[9:0]      out  pixel row; holds its last value while de=0
//   line_end    out  one-cycle pulse on the last pixel of each line
//   frame_start out  one-cycle pulse at pixel (0,0)
//   rgb[11:0]   out  4:4:4 pixel colour
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned SYNC_POS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] count,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_end,
  output logic        frame_start,
  output logic [11:0] rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VA     = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  localparam logic SYNC_ACT = (SYNC_POS != 0);

  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        line_end_q, line_end_d;
  logic        frame_start_q, frame_start_d;

  logic h_active, v_active, hs_win, vs_win;

  // Every horizontal window decoded here lies below H_TOTAL. So an
  // out-of-range count (>= H_TOTAL) decodes as blanked, with no sync and no
  // pulses, and leaves v_cnt alone without any explicit range check.
  always_comb begin
    h_active      = (count < HA);
    hs_win        = (count >= HS_BEG) && (count < HS_END);
    v_active      = (v_cnt_q < VA);
    vs_win        = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    de_d          = h_active & v_active;
    hsync_d       = hs_win ? SYNC_ACT : ~SYNC_ACT;
    vsync_d       = vs_win ? SYNC_ACT : ~SYNC_ACT;
    line_end_d    = (count == H_LAST);
    frame_start_d = (count == 11'd0) && (v_cnt_q == 10'd0);
    x_d           = de_d ? count   : x_q;
    y_d           = de_d ? v_cnt_q : y_q;

    v_cnt_d = v_cnt_q;
    if (line_end_d)
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [11:0] rgb_q, rgb_d;

  // The bar index comes from threshold compares, so no divider is needed.
  // Each bar lights R, G and B fully or not at all. The order is white,
  // yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++)
      if (count >= 11'(i * BAR_W)) bar = 3'(i);
    rgb_d = 12'h000;
    if (de_d) begin
      case (bar)
        3'd0:    rgb_d = 12'hFFF;
        3'd1:    rgb_d = 12'hFF0;
        3'd2:    rgb_d = 12'h0FF;
        3'd3:    rgb_d = 12'h0F0;
        3'd4:    rgb_d = 12'hF0F;
        3'd5:    rgb_d = 12'hF00;
        3'd6:    rgb_d = 12'h00F;
        default: rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`else
  assign rgb = 12'h000;
`endif

endmodule
